// File: rtl/ula_mdu.sv
// ula_mdu: execution-stage ALU plus iterative 32-step multiply/divide into HI/LO.
// Optional macro ULA_DIVZERO_FLAG_EN adds the div_zero output pulse.
module ula_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       OP,
  input  logic             op_unsigned,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ULA_DIVZERO_FLAG_EN
  ,output logic            div_zero
`endif
);
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR = 4'h4, OP_XOR = 4'h5, OP_NOR = 4'h6, OP_SLL = 4'h7,
                         OP_SRL = 4'h8, OP_SRA = 4'h9, OP_SLT = 4'hA, OP_SLTU = 4'hB,
                         OP_MULT = 4'hC, OP_DIV = 4'hD, OP_ADDU = 4'hE, OP_SUBU = 4'hF;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, mcd_q, mcd_d;
  logic zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;
  logic is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic [WIDTH-1:0] sum, diff, alu, ma, mb, n_acc, n_low, quo, rem;
  logic [WIDTH:0] mul_sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic add_ovf, sub_ovf, sa, sb, mdu_op;
`ifdef ULA_DIVZERO_FLAG_EN
  logic div_zero_q, div_zero_d;
  assign div_zero = div_zero_q;
`endif
  always_comb begin
    sum = A + B;
    diff = A - B;
    add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    case (OP)
      OP_ADD, OP_ADDU: alu = sum;
      OP_SUB, OP_SUBU: alu = diff;
      OP_AND:  alu = A & B;
      OP_OR:   alu = A | B;
      OP_XOR:  alu = A ^ B;
      OP_NOR:  alu = ~(A | B);
      OP_SLL:  alu = B << shamt;
      OP_SRL:  alu = B >> shamt;
      OP_SRA:  alu = WIDTH'($signed(B) >>> shamt);
      OP_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: alu = {{(WIDTH-1){1'b0}}, A < B};
      default: alu = '0;
    endcase
    mdu_op = (OP == OP_MULT) || (OP == OP_DIV);
    sa = ~op_unsigned & A[WIDTH-1];
    sb = ~op_unsigned & B[WIDTH-1];
    ma = sa ? -A : A;
    mb = sb ? -B : B;
    // One shift-add or restoring-divide step on {acc, low}
    mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, mcd_q} : '0);
    trial = {acc_q, low_q[WIDTH-1]} - {1'b0, mcd_q};
    n_acc = is_div_q ? (trial[WIDTH] ? {acc_q[WIDTH-2:0], low_q[WIDTH-1]} : trial[WIDTH-1:0])
                     : mul_sum[WIDTH:1];
    n_low = is_div_q ? {low_q[WIDTH-2:0], ~trial[WIDTH]} : {mul_sum[0], low_q[WIDTH-1:1]};
    prod = neg_p_q ? -{n_acc, n_low} : {n_acc, n_low};
    quo = dz_q ? '1 : (neg_p_q ? -n_low : n_low);
    rem = neg_r_q ? -n_acc : n_acc;
    state_d = state_q;
    cnt_d = cnt_q;
    result_d = result_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    acc_d = acc_q;
    low_d = low_q;
    mcd_d = mcd_q;
    is_div_d = is_div_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    dz_d = dz_q;
`ifdef ULA_DIVZERO_FLAG_EN
    div_zero_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (start && mdu_op) begin
        state_d = RUN;
        cnt_d = SHW'(WIDTH-1);
        acc_d = '0;
        low_d = ma;
        mcd_d = mb;
        is_div_d = OP == OP_DIV;
        neg_p_d = sa ^ sb;
        neg_r_d = sa;
        dz_d = (OP == OP_DIV) && (B == '0);
      end else if (start) begin
        result_d = alu;
        zero_d = alu == '0;
        ovf_d = (OP == OP_ADD) ? add_ovf : (OP == OP_SUB) ? sub_ovf : 1'b0;
        done_d = 1'b1;
      end
      RUN: begin
        acc_d = n_acc;
        low_d = n_low;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          hi_d = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
          lo_d = is_div_q ? quo : prod[WIDTH-1:0];
          result_d = lo_d;
          zero_d = lo_d == '0;
          ovf_d = 1'b0;
          done_d = 1'b1;
`ifdef ULA_DIVZERO_FLAG_EN
          div_zero_d = dz_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      result_q <= '0;
      zero_q <= 1'b1;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      acc_q <= '0;
      low_q <= '0;
      mcd_q <= '0;
      is_div_q <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q <= 1'b0;
`ifdef ULA_DIVZERO_FLAG_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      acc_q <= acc_d;
      low_q <= low_d;
      mcd_q <= mcd_d;
      is_div_q <= is_div_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      dz_q <= dz_d;
`ifdef ULA_DIVZERO_FLAG_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end
  assign result = result_q;
  assign zero = zero_q;
  assign overflow = ovf_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_ula_mdu.sv
// tb_ula_mdu: table-driven directed checks of ula_mdu plus multi-cycle corner sequences.
module tb_ula_mdu;
  logic clk = 1'b0, reset, start, op_unsigned;
  logic [3:0] OP;
  logic [31:0] A, B, result, hi, lo;
  logic [4:0] shamt;
  logic zero, overflow, busy, done;
  int checks = 0, errors = 0;
`ifdef ULA_DIVZERO_FLAG_EN
  logic div_zero;
`endif
  always #5 clk = ~clk;
  ula_mdu #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .OP(OP), .op_unsigned(op_unsigned),
    .A(A), .B(B), .shamt(shamt), .result(result), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef ULA_DIVZERO_FLAG_EN
    , .div_zero(div_zero)
`endif
  );
  typedef struct {
    string name;
    logic [3:0] op;
    logic uns;
    logic [31:0] a, b;
    logic [4:0] sh;
    logic mdu;
    logic [31:0] res, ehi, elo;
    logic ez, eo;
  } vec_t;
  vec_t vecs[23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int seen = 0, lat = 0;
    OP = v.op; op_unsigned = v.uns; A = v.a; B = v.b; shamt = v.sh; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) chk({v.name, " busy"}, {31'b0, busy}, {31'b0, v.mdu});
      if (done === 1'b1) begin
        seen++;
        if (seen == 1) begin
          lat = c;
          chk({v.name, " result"}, result, v.res);
          chk({v.name, " zero"}, {31'b0, zero}, {31'b0, v.ez});
          chk({v.name, " ovf"}, {31'b0, overflow}, {31'b0, v.eo});
          if (v.mdu) begin
            chk({v.name, " hi"}, hi, v.ehi);
            chk({v.name, " lo"}, lo, v.elo);
          end
`ifdef ULA_DIVZERO_FLAG_EN
          chk({v.name, " div_zero"}, {31'b0, div_zero}, {31'b0, v.op == 4'hD && v.b == 0});
`endif
        end
      end
    end
    chk({v.name, " latency"}, lat, v.mdu ? 33 : 1);
    chk({v.name, " done count"}, seen, 1);
  endtask
  initial begin
    vecs[0]  = '{"add_ovf", 4'h1, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 0, 0, 1};
    vecs[1]  = '{"sub_eq", 4'h2, 0, 32'd9, 32'd9, 0, 0, 32'h0, 0, 0, 1, 0};
    vecs[2]  = '{"sra", 4'h9, 0, 32'h0, 32'h80000000, 4, 0, 32'hF8000000, 0, 0, 0, 0};
    vecs[3]  = '{"sltu", 4'hB, 0, 32'h1, 32'hFFFFFFFF, 0, 0, 32'h1, 0, 0, 0, 0};
    vecs[4]  = '{"slt", 4'hA, 0, 32'h1, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0, 1, 0};
    vecs[5]  = '{"sll", 4'h7, 0, 32'h0, 32'h1, 31, 0, 32'h80000000, 0, 0, 0, 0};
    vecs[6]  = '{"srl", 4'h8, 0, 32'h0, 32'h80000000, 31, 0, 32'h1, 0, 0, 0, 0};
    vecs[7]  = '{"and", 4'h3, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 32'h00F000F0, 0, 0, 0, 0};
    vecs[8]  = '{"or", 4'h4, 0, 32'hF0F00000, 32'h0000F0F0, 0, 0, 32'hF0F0F0F0, 0, 0, 0, 0};
    vecs[9]  = '{"xor", 4'h5, 0, 32'hFFFF0000, 32'hFF00FF00, 0, 0, 32'h00FFFF00, 0, 0, 0, 0};
    vecs[10] = '{"nor", 4'h6, 0, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0};
    vecs[11] = '{"nop", 4'h0, 0, 32'd5, 32'd6, 0, 0, 32'h0, 0, 0, 1, 0};
    vecs[12] = '{"sub_ovf", 4'h2, 0, 32'h80000000, 32'h1, 0, 0, 32'h7FFFFFFF, 0, 0, 0, 1};
    vecs[13] = '{"addu", 4'hE, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 0, 0, 0};
    vecs[14] = '{"subu", 4'hF, 0, 32'h0, 32'h1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0};
    vecs[15] = '{"mult_s", 4'hC, 0, 32'hFFFFFFFD, 32'd7, 0, 1, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0};
    vecs[16] = '{"multu", 4'hC, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'h1, 32'hFFFFFFFE, 32'h1, 0, 0};
    vecs[17] = '{"div_s", 4'hD, 0, 32'hFFFFFFF9, 32'd2, 0, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0};
    vecs[18] = '{"div_z", 4'hD, 0, 32'd5, 32'd0, 0, 1, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 0, 0};
    vecs[19] = '{"div_min", 4'hD, 0, 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h80000000, 32'h0, 32'h80000000, 0, 0};
    vecs[20] = '{"divu", 4'hD, 1, 32'd100, 32'd7, 0, 1, 32'd14, 32'd2, 32'd14, 0, 0};
    vecs[21] = '{"div_neg_b", 4'hD, 0, 32'd7, 32'hFFFFFFFE, 0, 1, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFD, 0, 0};
    vecs[22] = '{"mult_nn", 4'hC, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'h1, 32'h0, 32'h1, 0, 0};
    reset = 1'b1; start = 1'b0; OP = 4'h0; op_unsigned = 1'b0; A = '0; B = '0; shamt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst result", result, 32'h0);
    chk("rst flags", {27'b0, zero, overflow, busy, done, 1'b0}, {27'b0, 5'b10000});
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    foreach (vecs[i]) run_vec(vecs[i]);
    // back-to-back single-cycle ops
    OP = 4'h1; A = 32'd2; B = 32'd3; start = 1'b1;
    @(negedge clk);
    A = 32'd10; B = 32'd20;
    chk("b2b done1", {31'b0, done}, 32'd1);
    chk("b2b res1", result, 32'd5);
    @(negedge clk);
    start = 1'b0;
    chk("b2b done2", {31'b0, done}, 32'd1);
    chk("b2b res2", result, 32'd30);
    @(negedge clk);
    chk("b2b done3", {31'b0, done}, 32'd0);
    chk("b2b hold", result, 32'd30);
    // start during MULT must be ignored
    begin
      int n = 0, lat = 0;
      OP = 4'hC; op_unsigned = 1'b0; A = 32'd3; B = 32'd5; start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        start = (c == 5);
        OP = (c == 5) ? 4'h1 : 4'hC;
        if (done === 1'b1) begin n++; lat = c; end
        if (c == 33) chk("ign result", result, 32'd15);
        if (c == 33) chk("ign busy fin", {31'b0, busy}, 32'd1);
        if (c == 34) chk("ign busy after", {31'b0, busy}, 32'd0);
      end
      chk("ign done count", n, 1);
      chk("ign latency", lat, 33);
    end
    // reset mid-RUN aborts without a done
    begin
      int n = 0;
      OP = 4'hC; A = 32'd6; B = 32'd7; start = 1'b1;
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk);
        start = 1'b0;
        reset = (c == 10);
        if (done === 1'b1) n++;
        if (c == 11) begin
          chk("abort busy", {31'b0, busy}, 32'd0);
          chk("abort hi", hi, 32'h0);
          chk("abort lo", lo, 32'h0);
          chk("abort result", result, 32'h0);
          chk("abort zero", {31'b0, zero}, 32'd1);
        end
      end
      chk("abort no done", n, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
